rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
- Shares the single register-file write port between two writeback sources.
  - Port 0: the single-cycle ALU path.
  - Port 1: long-latency units such as the multiplier or load unit.
- Keeps a per-register busy scoreboard so that issue stalls on RAW/WAW hazards against pending long-latency writes.
- Sits between the execute/writeback units and the register file. Drives its write-enable, write-address and write-data inputs directly.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- p0_valid  input  1  ALU writeback request
- p0_ready  output  1  ALU writeback granted this cycle
- p0_addr  input  AW  ALU destination register
- p0_data  input  DW  ALU result
- p1_valid  input  1  long-latency writeback request
- p1_ready  output  1  long-latency writeback granted this cycle
- p1_addr  input  AW  long-latency destination register
- p1_data  input  DW  long-latency result
- iss_valid  input  1  instruction attempting issue
- iss_long  input  1  issuing instruction completes via port 1
- iss_rd  input  AW  issuing instruction destination
- iss_rs0  input  AW  issuing instruction source 0
- iss_rs1  input  AW  issuing instruction source 1
- stall  output  1  issue blocked this cycle
- busy_o  output  NREG  scoreboard state, bit i = register i pending
- rf_we  output  1  register-file write enable
- rf_wa  output  AW  register-file write address
- rf_wd  output  DW  register-file write data
- wb_err  output  1  sticky writeback protocol error

Behaviour:
- Reset:
  - With rst_n=0 at a rising edge: busy=0, prio=0, wb_err=0.
  - While rst_n=0: p0_ready=0, p1_ready=0, rf_we=0, rf_wa=0, rf_wd=0, stall=1.
- Arbitration (combinational, zero latency):
  - Only one port valid → that port is granted.
  - Both valid → the port selected by prio is granted.
  - Neither valid → no grant.
  - p0_ready/p1_ready equal their grant signal.
  - A handshake is valid&ready. A requester holds valid, addr and data stable until its ready is high.
- Priority register:
  - On any handshake by port k, prio <= the other port.
  - No handshake → prio holds.
  - Round-robin guarantees each port waits at most 1 cycle under contention.
- Register-file drive:
  - On a grant: rf_wa and rf_wd come from the granted port; rf_we = grant && addr!=0.
  - Writes to register 0 complete the handshake but rf_we stays 0.
  - No grant → rf_we=0, rf_wa=0, rf_wd=0.
  - The register file captures the write on the same edge.
- Stall (computed from registered busy only):
  - stall = iss_valid && (busy[iss_rs0] || busy[iss_rs1] || busy[iss_rd]), with index 0 never busy.
  - A register whose writeback handshakes this cycle still stalls this cycle. The register file read is combinational and returns the old value until the edge.
  - Reads and writes of register 0 never stall.
- Scoreboard update (rising edge, rst_n=1):
  - Clear: a port 1 handshake with p1_addr!=0 clears busy[p1_addr].
  - Set: iss_valid && !stall && iss_long && iss_rd!=0 sets busy[iss_rd].
  - Set and clear of the same index in the same cycle → set wins. This case is unreachable under correct stall, but is defined anyway.
  - busy[0] is always 0.
  - Port 0 handshakes never modify busy.
- wb_err (sticky until reset), set on either of:
  - a port 1 handshake with p1_addr!=0 and busy[p1_addr]=0;
  - a port 0 handshake with p0_addr!=0 and busy[p0_addr]=1.
- Reset mid-operation:
  - In-flight requests are not granted during reset. Requesters re-present them after reset.
  - The scoreboard is lost on reset; upstream flushes its long-latency units with the same reset.
- No internal buffering: every write is combinational pass-through gated by arbitration.

Test Plan:
- Single writes: p0 valid, addr=5, data=0x1234 → same cycle p0_ready=1, rf_we=1, rf_wa=5, rf_wd=0x1234. Idle cycle → rf_we=0, rf_wa=0, rf_wd=0.
- Contention: both valid for 4 cycles after reset, p0 addr=3, p1 addr=7 with busy[7]=1 → grants alternate p0,p1,p0,p1.
  - busy[7] clears after the first p1 grant.
  - wb_err rises after the second p1 grant (busy[7] already 0).
- Hazards:
  - Issue long with rd=9 → busy[9]=1 next cycle.
  - Next issue rs0=9 → stall=1.
  - p1 handshake addr=9 → stall still 1 that cycle, 0 the following cycle.
- WAW: issue long rd=4 → busy[4]=1; then issue short rd=4 → stall=1 until the p1 writeback for register 4 completes.
- Register 0:
  - p1 write addr=0 → p1_ready=1, rf_we=0, wb_err stays 0.
  - Issue long rd=0 → busy_o stays 0.
  - Sources rs0=rs1=0 → stall=0.
- Reset mid-stream: busy=0x0000_0600, prio=1, both ports valid, rst_n=0 for one edge.
  - During reset: readies=0, stall=1.
  - After the edge: busy_o=0, wb_err=0, and the first contended grant goes to p0.

Source files
------------

// File: rtl/rf_wb_scheduler_if.sv
// Writeback, issue and register-file signals of rf_wb_scheduler. The master side
// (execute/writeback units) drives requests and the slave side (scheduler) answers them.
interface rf_wb_scheduler_if #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
);
  logic            p0_valid;
  logic            p0_ready;
  logic [AW-1:0]   p0_addr;
  logic [DW-1:0]   p0_data;
  logic            p1_valid;
  logic            p1_ready;
  logic [AW-1:0]   p1_addr;
  logic [DW-1:0]   p1_data;
  logic            iss_valid;
  logic            iss_long;
  logic [AW-1:0]   iss_rd;
  logic [AW-1:0]   iss_rs0;
  logic [AW-1:0]   iss_rs1;
  logic            stall;
  logic [NREG-1:0] busy_o;
  logic            rf_we;
  logic [AW-1:0]   rf_wa;
  logic [DW-1:0]   rf_wd;
  logic            wb_err;

  modport master (
    output p0_valid, p0_addr, p0_data, p1_valid, p1_addr, p1_data,
    output iss_valid, iss_long, iss_rd, iss_rs0, iss_rs1,
    input  p0_ready, p1_ready, stall, busy_o, rf_we, rf_wa, rf_wd, wb_err
  );

  modport slave (
    input  p0_valid, p0_addr, p0_data, p1_valid, p1_addr, p1_data,
    input  iss_valid, iss_long, iss_rd, iss_rs0, iss_rs1,
    output p0_ready, p1_ready, stall, busy_o, rf_we, rf_wa, rf_wd, wb_err
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the single register-file write port between the ALU (port 0) and
// long-latency units (port 1), and keeps a busy scoreboard that stalls hazardous issue.
module rf_wb_scheduler #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input logic             clk,
  input logic             rst_n,
  rf_wb_scheduler_if.slave bus
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            prio_q, prio_d;
  logic            err_q, err_d;
  logic            gnt0, gnt1;
  logic            we;
  logic [AW-1:0]   wa;
  logic [DW-1:0]   wd;
  logic            stall_c;
  logic            issue_set;

  // prio_q == 0 favours port 0 under contention; no grants at all while in reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (bus.p0_valid && bus.p1_valid) begin
        gnt0 = !prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = bus.p0_valid;
        gnt1 = bus.p1_valid;
      end
    end
  end

  always_comb begin
    we = 1'b0;
    wa = '0;
    wd = '0;
    if (gnt0) begin
      wa = bus.p0_addr;
      wd = bus.p0_data;
      we = (bus.p0_addr != '0);
    end else if (gnt1) begin
      wa = bus.p1_addr;
      wd = bus.p1_data;
      we = (bus.p1_addr != '0);
    end
  end

  // Uses registered busy only: a same-cycle writeback still stalls, since the RF read is stale
  always_comb begin
    stall_c = 1'b1;
    if (rst_n) begin
      stall_c = bus.iss_valid &&
                (busy_q[bus.iss_rs0] || busy_q[bus.iss_rs1] || busy_q[bus.iss_rd]);
    end
  end

  always_comb begin
    busy_d    = busy_q;
    prio_d    = prio_q;
    err_d     = err_q;
    issue_set = bus.iss_valid && !stall_c && bus.iss_long && (bus.iss_rd != '0);
    if (gnt1 && (bus.p1_addr != '0)) begin
      if (!busy_q[bus.p1_addr]) begin
        err_d = 1'b1;
      end
      busy_d[bus.p1_addr] = 1'b0;
    end
    if (gnt0 && (bus.p0_addr != '0) && busy_q[bus.p0_addr]) begin
      err_d = 1'b1;
    end
    // Applied after the clear so a same-index set wins
    if (issue_set) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      prio_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      prio_q <= prio_d;
      err_q  <= err_d;
    end
  end

  assign bus.p0_ready = gnt0;
  assign bus.p1_ready = gnt1;
  assign bus.stall    = stall_c;
  assign bus.busy_o   = busy_q;
  assign bus.rf_we    = we;
  assign bus.rf_wa    = wa;
  assign bus.rf_wd    = wd;
  assign bus.wb_err   = err_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Scoreboard bench for rf_wb_scheduler: directed scenarios then randomized traffic,
// each cycle's expected outputs come from a behavioural model and are queued for a monitor.
module tb_rf_wb_scheduler;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;

  typedef struct {
    logic        p0r;
    logic        p1r;
    logic        st;
    logic [31:0] busy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rf_wb_scheduler_if #(.NREG(NREG), .AW(AW), .DW(DW)) bus ();

  rf_wb_scheduler #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stimulus variables
  bit          rst_v;
  bit          p0v, p1v, isv, isl;
  logic [4:0]  p0a, p1a, ird, irs0, irs1;
  logic [31:0] p0d, p1d;

  // Reference model state
  bit busy_m [NREG];
  bit prio_m;
  bit err_m;
  bit g0, g1, acc_long;

  exp_t expq [$];
  int   checks;
  int   failures;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic apply();
    rst_n         = rst_v;
    bus.p0_valid  = p0v;
    bus.p0_addr   = p0a;
    bus.p0_data   = p0d;
    bus.p1_valid  = p1v;
    bus.p1_addr   = p1a;
    bus.p1_data   = p1d;
    bus.iss_valid = isv;
    bus.iss_long  = isl;
    bus.iss_rd    = ird;
    bus.iss_rs0   = irs0;
    bus.iss_rs1   = irs1;
  endtask

  task automatic clear_inputs();
    p0v = 0; p1v = 0; isv = 0; isl = 0;
    p0a = 0; p1a = 0; ird = 0; irs0 = 0; irs1 = 0;
    p0d = 0; p1d = 0;
  endtask

  // One clock cycle: drive inputs, queue what the outputs must be, advance the model
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    apply();
    g0 = 0;
    g1 = 0;
    if (rst_v) begin
      if (p0v && p1v) begin
        g0 = (prio_m == 0);
        g1 = (prio_m == 1);
      end else begin
        g0 = p0v;
        g1 = p1v;
      end
    end
    e.p0r = g0;
    e.p1r = g1;
    e.st  = !rst_v || (isv && (busy_m[irs0] || busy_m[irs1] || busy_m[ird]));
    for (int i = 0; i < NREG; i++) e.busy[i] = busy_m[i];
    e.err = err_m;
    e.we  = 0;
    e.wa  = 0;
    e.wd  = 0;
    if (g0) begin
      e.wa = p0a; e.wd = p0d; e.we = (p0a != 0);
    end else if (g1) begin
      e.wa = p1a; e.wd = p1d; e.we = (p1a != 0);
    end
    expq.push_back(e);
    acc_long = 0;
    if (!rst_v) begin
      for (int i = 0; i < NREG; i++) busy_m[i] = 0;
      prio_m = 0;
      err_m  = 0;
    end else begin
      if (g1 && p1a != 0) begin
        if (!busy_m[p1a]) err_m = 1;
        busy_m[p1a] = 0;
      end
      if (g0 && p0a != 0 && busy_m[p0a]) err_m = 1;
      if (isv && !e.st && isl && ird != 0) begin
        busy_m[ird] = 1;
        acc_long    = 1;
      end
      if (g0) prio_m = 1;
      else if (g1) prio_m = 0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("p0_ready", bus.p0_ready, e.p0r);
      chk("p1_ready", bus.p1_ready, e.p1r);
      chk("stall", bus.stall, e.st);
      chk("busy_o", bus.busy_o, e.busy);
      chk("rf_we", bus.rf_we, e.we);
      chk("rf_wa", bus.rf_wa, e.wa);
      chk("rf_wd", bus.rf_wd, e.wd);
      chk("wb_err", bus.wb_err, e.err);
    end
  end

  int pending [$];

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    rst_v = 0;
    apply();
    // Bring DUT state out of X before anything is scored
    repeat (2) @(posedge clk);
    step();
    step();
    rst_v = 1;

    // Single write then idle
    p0v = 1; p0a = 5; p0d = 32'h1234;
    step(); sample();
    chk("single_p0_ready", bus.p0_ready, 1);
    chk("single_rf_we", bus.rf_we, 1);
    chk("single_rf_wa", bus.rf_wa, 5);
    chk("single_rf_wd", bus.rf_wd, 32'h1234);
    p0v = 0;
    step(); sample();
    chk("idle_rf_we", bus.rf_we, 0);
    chk("idle_rf_wa", bus.rf_wa, 0);
    chk("idle_rf_wd", bus.rf_wd, 0);

    // Contention with busy[7] pending
    rst_v = 0; step(); rst_v = 1;
    isv = 1; isl = 1; ird = 7;
    step();
    isv = 0; isl = 0; ird = 0;
    p0v = 1; p0a = 3; p0d = $urandom;
    p1v = 1; p1a = 7; p1d = $urandom;
    for (int k = 0; k < 4; k++) begin
      step(); sample();
      chk("contend_p0_ready", bus.p0_ready, (k % 2 == 0) ? 1 : 0);
      chk("contend_p1_ready", bus.p1_ready, (k % 2 == 1) ? 1 : 0);
      if (k == 0) chk("contend_busy7_set", bus.busy_o[7], 1);
      if (k == 2) chk("contend_busy7_clr", bus.busy_o[7], 0);
    end
    p0v = 0; p1v = 0;
    step(); sample();
    chk("contend_wb_err", bus.wb_err, 1);

    // RAW hazard on register 9
    isv = 1; isl = 1; ird = 9;
    step();
    isl = 0; ird = 0; irs0 = 9;
    step(); sample();
    chk("raw_busy9", bus.busy_o[9], 1);
    chk("raw_stall", bus.stall, 1);
    p1v = 1; p1a = 9; p1d = $urandom;
    step(); sample();
    chk("raw_wb_ready", bus.p1_ready, 1);
    chk("raw_stall_wb_cycle", bus.stall, 1);
    p1v = 0;
    step(); sample();
    chk("raw_stall_after", bus.stall, 0);
    isv = 0; irs0 = 0;

    // WAW hazard on register 4
    isv = 1; isl = 1; ird = 4;
    step();
    isl = 0;
    step(); sample();
    chk("waw_stall_a", bus.stall, 1);
    step(); sample();
    chk("waw_stall_b", bus.stall, 1);
    p1v = 1; p1a = 4; p1d = $urandom;
    step(); sample();
    chk("waw_stall_wb_cycle", bus.stall, 1);
    p1v = 0;
    step(); sample();
    chk("waw_stall_after", bus.stall, 0);
    isv = 0; ird = 0;

    // Register 0 behaviour
    rst_v = 0; step(); rst_v = 1;
    p1v = 1; p1a = 0; p1d = $urandom;
    step(); sample();
    chk("r0_p1_ready", bus.p1_ready, 1);
    chk("r0_rf_we", bus.rf_we, 0);
    p1v = 0;
    step(); sample();
    chk("r0_wb_err", bus.wb_err, 0);
    isv = 1; isl = 1; ird = 0; irs0 = 0; irs1 = 0;
    step();
    isl = 0;
    step(); sample();
    chk("r0_busy_o", bus.busy_o, 0);
    chk("r0_stall", bus.stall, 0);
    isv = 0;

    // Reset in the middle of contended traffic
    isv = 1; isl = 1; ird = 9;
    step();
    ird = 10;
    step();
    isv = 0; isl = 0; ird = 0;
    p0v = 1; p0a = 0; p0d = $urandom;
    step();
    p0a = 3; p1v = 1; p1a = 9; p1d = $urandom;
    rst_v = 0;
    step(); sample();
    chk("rst_p0_ready", bus.p0_ready, 0);
    chk("rst_p1_ready", bus.p1_ready, 0);
    chk("rst_stall", bus.stall, 1);
    chk("rst_busy_before_edge", bus.busy_o, 32'h0000_0600);
    rst_v = 1;
    step(); sample();
    chk("rst_busy_after", bus.busy_o, 0);
    chk("rst_wb_err_after", bus.wb_err, 0);
    chk("rst_first_grant_p0", bus.p0_ready, 1);
    chk("rst_first_grant_not_p1", bus.p1_ready, 0);
    p0v = 0;
    step();
    p1v = 0;

    // Randomized traffic
    clear_inputs();
    rst_v = 0; step(); rst_v = 1;
    pending.delete();
    for (int c = 0; c < 3000; c++) begin
      rst_v = ($urandom_range(0, 299) != 0);
      if (!p0v && ($urandom_range(0, 2) == 0)) begin
        p0v = 1; p0a = 5'($urandom_range(0, 7)); p0d = $urandom;
      end
      if (!p1v && ($urandom_range(0, 1) == 0)) begin
        if (pending.size() > 0) begin
          p1v = 1;
          p1a = 5'(pending[$urandom_range(0, pending.size() - 1)]);
          p1d = $urandom;
        end else if ($urandom_range(0, 7) == 0) begin
          p1v = 1; p1a = 5'($urandom_range(0, 7)); p1d = $urandom;
        end
      end
      isv  = $urandom_range(0, 1) == 1;
      isl  = $urandom_range(0, 1) == 1;
      ird  = 5'($urandom_range(0, 7));
      irs0 = 5'($urandom_range(0, 7));
      irs1 = 5'($urandom_range(0, 7));
      step();
      if (g0) p0v = 0;
      if (g1) begin
        p1v = 0;
        for (int i = 0; i < pending.size(); i++) begin
          if (pending[i] == int'(p1a)) begin
            pending.delete(i);
            break;
          end
        end
      end
      if (acc_long) pending.push_back(int'(ird));
      if (!rst_v) begin
        pending.delete();
        p1v = 0;
      end
    end

    clear_inputs();
    rst_v = 1;
    step();
    sample();
    chk("scoreboard_drain", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
